irq_responder: RTL and testbench
================================

IRQ_RESPONDER -- requirements
Module: irq_responder

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning cycles in WAIT_ACK before timeout pulses (range 1..255).
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port irq_req, input, 4, level interrupt requests from sources; bit 0 is highest priority.
REQ-005 The block SHALL have port irq_mask, input, 4, per-bit enable; 1 = eligible for dispatch.
REQ-006 The block SHALL have port cpu_ack, input, 1, CPU acknowledge of the presented interrupt.
REQ-007 The block SHALL have port cpu_int, output, 1, interrupt request to the CPU.
REQ-008 The block SHALL have port cpu_vector, output, 2, index of the presented interrupt.
REQ-009 The block SHALL have port irq_ack, output, 4, one-hot, one-cycle acknowledge pulse back to the granted source.
REQ-010 The block SHALL have port pending, output, 4, the registered pending vector.
REQ-011 The block SHALL have port timeout, output, 1, one-cycle pulse on ack timeout.
REQ-012 The block SHALL have port spurious, output, 1, one-cycle pulse on cpu_ack outside WAIT_ACK.

Function
REQ-013 pending[i] SHALL set on the clock edge where irq_req[i]=1 and the previously registered irq_req[i]=0 (rising-edge capture); it is sticky.
REQ-014 pending[i] SHALL clear only on the cycle irq_ack[i] pulses; a new rising edge on the same bit in that cycle SHALL win (bit stays set).
REQ-015 FSM states SHALL be IDLE, WAIT_ACK, ACK.
REQ-016 IDLE -> WAIT_ACK SHALL occur when (pending & irq_mask) != 0; cpu_vector SHALL latch the lowest set index of that vector on the same edge.
REQ-017 cpu_int SHALL be 1 exactly while in WAIT_ACK; latency from irq_req rising to cpu_int=1 is 2 cycles when masked-in and IDLE.
REQ-018 cpu_vector SHALL stay stable throughout WAIT_ACK; a higher-priority arrival SHALL NOT preempt.
REQ-019 WAIT_ACK -> ACK SHALL occur on cpu_ack=1; in ACK, irq_ack SHALL be one-hot at cpu_vector for exactly one cycle, then the FSM returns to IDLE.
REQ-020 A wait counter SHALL count cycles in WAIT_ACK; on reaching TIMEOUT without cpu_ack, timeout SHALL pulse one cycle, the counter SHALL restart, and the FSM SHALL stay in WAIT_ACK.
REQ-021 cpu_ack in IDLE or ACK SHALL pulse spurious one cycle and SHALL be otherwise ignored.
REQ-022 Masking a bit during WAIT_ACK SHALL NOT withdraw the presented interrupt; masked bits remain pending.
REQ-023 When ACK returns to IDLE with further eligible bits, the next WAIT_ACK entry SHALL follow on the next edge, giving 1 idle cycle between cpu_int assertions.

Reset
REQ-024 Reset SHALL force state IDLE, pending=0, registered irq_req=0, cpu_vector=0, wait counter=0, and cpu_int, irq_ack, timeout, spurious all 0, immediately and independent of clock.
REQ-025 Reset asserted mid-WAIT_ACK SHALL drop cpu_int at once and discard the pending interrupt; after release, only new rising edges are captured.

Structure
REQ-026 Package irq_pkg SHALL hold NUM_IRQ=4, the FSM state enum typedef, and the vector index typedef.
REQ-027 Priority selection SHALL be a separate combinational sub-module irq_prio_enc (4-bit in, 2-bit index plus valid out).

Verification
REQ-028 irq_req=0100, mask=1111 -> cpu_int=1 two cycles later, cpu_vector=2; cpu_ack -> irq_ack=0100 one cycle, pending=0000.
REQ-029 irq_req=1010 same edge -> vector 1 served first, then vector 3 after 1 idle cycle; final pending=0000.
REQ-030 In WAIT_ACK on vector 3, raise irq_req[0] -> vector stays 3 until ack; vector 0 dispatched next.
REQ-031 irq_req=0001, mask=0000 -> no cpu_int, pending=0001; set mask=0001 -> cpu_int one cycle later.
REQ-032 TIMEOUT=4, no cpu_ack -> timeout pulses at 4 and 8 cycles in WAIT_ACK; cpu_ack in IDLE -> spurious pulse, no state change.
REQ-033 Assert reset mid-WAIT_ACK -> cpu_int=0 and pending=0000 without waiting for a clock edge; held-high irq_req not recaptured.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types for the interrupt responder: source count, FSM states and vector index.
package irq_pkg;
    localparam int NUM_IRQ = 4;
    localparam int VEC_W   = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        ACK
    } state_t;

    typedef logic [VEC_W-1:0] vec_t;

    function automatic logic [NUM_IRQ-1:0] onehot(input vec_t v);
        logic [NUM_IRQ-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins, valid when any bit is set.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output vec_t               idx,
    output logic               valid
);
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = vec_t'(i);
        end
    end
endmodule

// File: rtl/irq_responder.sv
// Interrupt responder: edge-captured pending bits, priority dispatch to the CPU,
// ack handshake with timeout and spurious-ack detection.
module irq_responder
    import irq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               cpu_ack,
    output logic               cpu_int,
    output vec_t               cpu_vector,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [NUM_IRQ-1:0] pending,
    output logic               timeout,
    output logic               spurious
);
    state_t             state;
    logic [7:0]         cnt;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] elig;
    logic               armed;
    vec_t               elig_idx;
    logic               elig_vld;

    // armed blocks capture on the first edge after reset so held-high requests
    // are not mistaken for fresh rising edges.
    assign rise = irq_req & ~irq_q & {NUM_IRQ{armed}};
    // The bit being acked is excluded so ACK can chain straight into the next dispatch.
    assign elig = pending & irq_mask & ~irq_ack;

    irq_prio_enc u_enc (
        .req   (elig),
        .idx   (elig_idx),
        .valid (elig_vld)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_q   <= '0;
            armed   <= 1'b0;
            pending <= '0;
        end else begin
            irq_q   <= irq_req;
            armed   <= 1'b1;
            pending <= (pending & ~irq_ack) | rise;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cpu_int    <= 1'b0;
            cpu_vector <= '0;
            irq_ack    <= '0;
            timeout    <= 1'b0;
            spurious   <= 1'b0;
        end else begin
            irq_ack  <= '0;
            timeout  <= 1'b0;
            spurious <= cpu_ack && (state != WAIT_ACK);
            case (state)
                IDLE, ACK: begin
                    cnt <= '0;
                    if (elig_vld) begin
                        state      <= WAIT_ACK;
                        cpu_vector <= elig_idx;
                        cpu_int    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_ACK: begin
                    if (cpu_ack) begin
                        state   <= ACK;
                        cpu_int <= 1'b0;
                        irq_ack <= onehot(cpu_vector);
                        cnt     <= '0;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cpu_int <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_responder.sv
// Bench for irq_responder: per-cycle vector table with a scoreboard queue, plus
// hand-written async reset sequences.
module tb_irq_responder;
    import irq_pkg::*;

    typedef struct packed {
        logic               cpu_int;
        logic [1:0]         vec;
        logic [NUM_IRQ-1:0] iack;
        logic [NUM_IRQ-1:0] pend;
        logic               to;
        logic               sp;
    } outs_t;

    typedef struct {
        logic [NUM_IRQ-1:0] req;
        logic [NUM_IRQ-1:0] mask;
        logic               ack;
        outs_t              exp;
    } row_t;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_IRQ-1:0] irq_req = '0;
    logic [NUM_IRQ-1:0] irq_mask = '0;
    logic               cpu_ack = 1'b0;
    logic               cpu_int;
    vec_t               cpu_vector;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [NUM_IRQ-1:0] pending;
    logic               timeout;
    logic               spurious;

    int    total = 0;
    int    bad   = 0;
    row_t  rows[$];
    outs_t expq[$];

    irq_responder #(.TIMEOUT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_req    (irq_req),
        .irq_mask   (irq_mask),
        .cpu_ack    (cpu_ack),
        .cpu_int    (cpu_int),
        .cpu_vector (cpu_vector),
        .irq_ack    (irq_ack),
        .pending    (pending),
        .timeout    (timeout),
        .spurious   (spurious)
    );

    always #5 clock = ~clock;

    function automatic outs_t sample();
        outs_t o;
        o.cpu_int = cpu_int;
        o.vec     = cpu_vector;
        o.iack    = irq_ack;
        o.pend    = pending;
        o.to      = timeout;
        o.sp      = spurious;
        return o;
    endfunction

    function automatic outs_t mko(logic i, int v, logic [3:0] a, logic [3:0] p, logic t, logic s);
        outs_t o;
        o.cpu_int = i;
        o.vec     = 2'(v);
        o.iack    = a;
        o.pend    = p;
        o.to      = t;
        o.sp      = s;
        return o;
    endfunction

    task automatic add(logic [3:0] rq, logic [3:0] mk, logic ak,
                       logic i, int v, logic [3:0] a, logic [3:0] p, logic t, logic s);
        row_t r;
        r.req  = rq;
        r.mask = mk;
        r.ack  = ak;
        r.exp  = mko(i, v, a, p, t, s);
        rows.push_back(r);
    endtask

    task automatic chk(string name, outs_t got, outs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got int=%b vec=%0d iack=%b pend=%b to=%b sp=%b want int=%b vec=%0d iack=%b pend=%b to=%b sp=%b",
                     name, got.cpu_int, got.vec, got.iack, got.pend, got.to, got.sp,
                     exp.cpu_int, exp.vec, exp.iack, exp.pend, exp.to, exp.sp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // req, mask, ack | cpu_int, vec, irq_ack, pending, timeout, spurious
        add(4'b0000, 4'b1111, 0,  0, 0, 4'b0000, 4'b0000, 0, 0);
        add(4'b0100, 4'b1111, 0,  0, 0, 4'b0000, 4'b0100, 0, 0);
        add(4'b0100, 4'b1111, 0,  1, 2, 4'b0000, 4'b0100, 0, 0);
        add(4'b0100, 4'b1111, 1,  0, 2, 4'b0100, 4'b0100, 0, 0);
        add(4'b0000, 4'b1111, 0,  0, 2, 4'b0000, 4'b0000, 0, 0);
        add(4'b1010, 4'b1111, 0,  0, 2, 4'b0000, 4'b1010, 0, 0);
        add(4'b1010, 4'b1111, 0,  1, 1, 4'b0000, 4'b1010, 0, 0);
        add(4'b1010, 4'b1111, 1,  0, 1, 4'b0010, 4'b1010, 0, 0);
        add(4'b1010, 4'b1111, 0,  1, 3, 4'b0000, 4'b1000, 0, 0);
        add(4'b1011, 4'b1111, 0,  1, 3, 4'b0000, 4'b1001, 0, 0);
        add(4'b1011, 4'b1111, 1,  0, 3, 4'b1000, 4'b1001, 0, 0);
        add(4'b1011, 4'b1111, 0,  1, 0, 4'b0000, 4'b0001, 0, 0);
        add(4'b1011, 4'b1111, 1,  0, 0, 4'b0001, 4'b0001, 0, 0);
        add(4'b0000, 4'b1111, 0,  0, 0, 4'b0000, 4'b0000, 0, 0);
        add(4'b0001, 4'b0000, 0,  0, 0, 4'b0000, 4'b0001, 0, 0);
        add(4'b0001, 4'b0000, 0,  0, 0, 4'b0000, 4'b0001, 0, 0);
        add(4'b0001, 4'b0001, 0,  1, 0, 4'b0000, 4'b0001, 0, 0);
        // masked out while presented: stays up, timeout every 4 cycles
        for (int k = 1; k <= 8; k++)
            add(4'b0001, 4'b0000, 0,  1, 0, 4'b0000, 4'b0001, (k % 4 == 0), 0);
        add(4'b0001, 4'b0000, 1,  0, 0, 4'b0001, 4'b0001, 0, 0);
        add(4'b0001, 4'b0000, 0,  0, 0, 4'b0000, 4'b0000, 0, 0);
        add(4'b0000, 4'b0000, 1,  0, 0, 4'b0000, 4'b0000, 0, 1);
        add(4'b0000, 4'b0000, 0,  0, 0, 4'b0000, 4'b0000, 0, 0);
        add(4'b0100, 4'b1111, 0,  0, 0, 4'b0000, 4'b0100, 0, 0);
        add(4'b0100, 4'b1111, 0,  1, 2, 4'b0000, 4'b0100, 0, 0);
        add(4'b0100, 4'b1111, 1,  0, 2, 4'b0100, 4'b0100, 0, 0);
        add(4'b0100, 4'b1111, 1,  0, 2, 4'b0000, 4'b0000, 0, 1);
        add(4'b0100, 4'b1111, 0,  0, 2, 4'b0000, 4'b0000, 0, 0);

        #1;
        chk("reset_state", sample(), mko(0, 0, 4'b0000, 4'b0000, 0, 0));
        tick();
        tick();
        reset = 1'b0;

        foreach (rows[n]) begin
            irq_req  = rows[n].req;
            irq_mask = rows[n].mask;
            cpu_ack  = rows[n].ack;
            expq.push_back(rows[n].exp);
            tick();
            chk($sformatf("row%0d", n), sample(), expq.pop_front());
        end
        cpu_ack = 1'b0;

        // asynchronous reset while an interrupt is presented
        irq_req  = 4'b0010;
        irq_mask = 4'b1111;
        tick();
        tick();
        chk("pre_reset_wait", sample(), mko(1, 1, 4'b0000, 4'b0010, 0, 0));
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", sample(), mko(0, 0, 4'b0000, 4'b0000, 0, 0));
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("no_recapture%0d", k), sample(), mko(0, 0, 4'b0000, 4'b0000, 0, 0));
        end
        irq_req = 4'b0000;
        tick();
        irq_req = 4'b0010;
        tick();
        chk("recapture", sample(), mko(0, 0, 4'b0000, 4'b0010, 0, 0));
        tick();
        chk("redispatch", sample(), mko(1, 1, 4'b0000, 4'b0010, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
